// File: rtl/n_term_io_pkg.sv
// Shared mode encodings and configuration field layout for the north-terminal turnaround tile.
package n_term_io_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned CFG_W  = 8;

    typedef enum logic [MODE_W-1:0] {
        MODE_BYPASS = 2'b00,
        MODE_RETIME = 2'b01,
        MODE_FREEZE = 2'b10,
        MODE_ZERO   = 2'b11
    } laneMode_t;

    // Field index of each wire group inside the mode register
    localparam int unsigned G1_IDX  = 0;
    localparam int unsigned G2_IDX  = 1;
    localparam int unsigned G2B_IDX = 2;
    localparam int unsigned G4_IDX  = 3;

    function automatic laneMode_t groupMode(input logic [CFG_W-1:0] cfg, input int unsigned idx);
        return laneMode_t'(cfg[idx*MODE_W +: MODE_W]);
    endfunction

endpackage

// File: rtl/n_term_io_cells.sv
// Plain buffer cells used for strobe and clock repeating.
module my_buf #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] X
);
    assign X = A;
endmodule

module clk_buf (
    input  logic A,
    output logic X
);
    assign X = A;
endmodule

// File: rtl/n_term_io_lane.sv
// One wire group: shift register that halts only in FREEZE, plus the mode-selected output mux.
module n_term_io_lane
    import n_term_io_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned PIPE_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  laneMode_t        mode,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut_c
);

    logic [WIDTH-1:0] stages [PIPE_DEPTH];
    logic             shiftEn;

    // Pipeline keeps real input history in every mode except FREEZE
    assign shiftEn = (mode != MODE_FREEZE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else if (shiftEn) begin
            stages[0] <= dataIn;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    always_comb begin
        dataOut_c = dataIn;
        unique case (mode)
            MODE_BYPASS: dataOut_c = dataIn;
            MODE_RETIME: dataOut_c = stages[PIPE_DEPTH-1];
            MODE_FREEZE: dataOut_c = stages[PIPE_DEPTH-1];
            MODE_ZERO:   dataOut_c = '0;
            default:     dataOut_c = dataIn;
        endcase
    end

endmodule

// File: rtl/n_term_io_pipe.sv
// North-terminal tile: loops N*END back to S*BEG with a frame-configured mode per wire group.
module n_term_io_pipe
    import n_term_io_pkg::*;
#(
    parameter int unsigned W1              = 4,
    parameter int unsigned W2              = 8,
    parameter int unsigned W4              = 16,
    parameter int unsigned PIPE_DEPTH      = 2,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned CFG_FRAME       = 0,
    parameter int unsigned CFG_LSB         = 0
) (
    input  logic                       UserCLK,
    input  logic                       Reset,
    input  logic [W1-1:0]              N1END,
    input  logic [W2-1:0]              N2MID,
    input  logic [W2-1:0]              N2END,
    input  logic [W4-1:0]              N4END,
    output logic [W1-1:0]              S1BEG,
    output logic [W2-1:0]              S2BEG,
    output logic [W2-1:0]              S2BEGb,
    output logic [W4-1:0]              S4BEG,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic                       UserCLKo
);

    logic [CFG_W-1:0] cfg;
    logic             unusedFrameData;

    // Only one byte of the frame row belongs to this tile
    assign unusedFrameData = ^FrameData;

    // Mode register; a held strobe rewrites it every edge
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            cfg <= '0;
        end else if (FrameStrobe[CFG_FRAME]) begin
            cfg <= FrameData[CFG_LSB +: CFG_W];
        end
    end

    n_term_io_lane #(.WIDTH(W1), .PIPE_DEPTH(PIPE_DEPTH)) u_laneG1 (
        .clk       (UserCLK),
        .rst       (Reset),
        .mode      (groupMode(cfg, G1_IDX)),
        .dataIn    (N1END),
        .dataOut_c (S1BEG)
    );

    n_term_io_lane #(.WIDTH(W2), .PIPE_DEPTH(PIPE_DEPTH)) u_laneG2 (
        .clk       (UserCLK),
        .rst       (Reset),
        .mode      (groupMode(cfg, G2_IDX)),
        .dataIn    (N2MID),
        .dataOut_c (S2BEG)
    );

    n_term_io_lane #(.WIDTH(W2), .PIPE_DEPTH(PIPE_DEPTH)) u_laneG2b (
        .clk       (UserCLK),
        .rst       (Reset),
        .mode      (groupMode(cfg, G2B_IDX)),
        .dataIn    (N2END),
        .dataOut_c (S2BEGb)
    );

    n_term_io_lane #(.WIDTH(W4), .PIPE_DEPTH(PIPE_DEPTH)) u_laneG4 (
        .clk       (UserCLK),
        .rst       (Reset),
        .mode      (groupMode(cfg, G4_IDX)),
        .dataIn    (N4END),
        .dataOut_c (S4BEG)
    );

    my_buf #(.WIDTH(MaxFramesPerCol)) u_strobeBuf (
        .A (FrameStrobe),
        .X (FrameStrobe_O)
    );

    clk_buf u_clkBuf (
        .A (UserCLK),
        .X (UserCLKo)
    );

endmodule

// File: tb/tb_n_term_io_pipe.sv
// Directed bench for n_term_io_pipe with the mode byte placed at FrameData[15:8].
module tb_n_term_io_pipe;

    logic        UserCLK = 1'b0;
    logic        Reset;
    logic [3:0]  N1END;
    logic [7:0]  N2MID;
    logic [7:0]  N2END;
    logic [15:0] N4END;
    logic [3:0]  S1BEG;
    logic [7:0]  S2BEG;
    logic [7:0]  S2BEGb;
    logic [15:0] S4BEG;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic [19:0] FrameStrobe_O;
    logic        UserCLKo;

    int nChecks = 0;
    int nFails  = 0;

    always #5 UserCLK = ~UserCLK;

    n_term_io_pipe #(
        .W1(4), .W2(8), .W4(16), .PIPE_DEPTH(2),
        .MaxFramesPerCol(20), .FrameBitsPerRow(32),
        .CFG_FRAME(0), .CFG_LSB(8)
    ) dut (
        .UserCLK       (UserCLK),
        .Reset         (Reset),
        .N1END         (N1END),
        .N2MID         (N2MID),
        .N2END         (N2END),
        .N4END         (N4END),
        .S1BEG         (S1BEG),
        .S2BEG         (S2BEG),
        .S2BEGb        (S2BEGb),
        .S4BEG         (S4BEG),
        .FrameData     (FrameData),
        .FrameStrobe   (FrameStrobe),
        .FrameStrobe_O (FrameStrobe_O),
        .UserCLKo      (UserCLKo)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge UserCLK);
        #1;
    endtask

    // One-edge strobe carrying a mode byte
    task automatic writeCfg(input logic [7:0] mode);
        FrameData   = {16'h0000, mode, 8'h00};
        FrameStrobe = 20'h00001;
        step();
        FrameStrobe = '0;
        FrameData   = '0;
    endtask

    initial begin
        // Reset: bypass, buffers transparent, strobe ignored
        Reset = 1'b1;
        N1END = 4'hA; N2MID = '0; N2END = '0; N4END = '0;
        FrameData = 32'h0000_5500; FrameStrobe = 20'h00005;
        #2;
        checkVal("rst_s1", 32'(S1BEG), 32'h0000_000A);
        checkVal("rst_fso", 32'(FrameStrobe_O), 32'h0000_0005);
        checkVal("rst_clko_lo", 32'(UserCLKo), 32'(UserCLK));
        step();
        N1END = 4'h5; N4END = 16'h0F0F;
        #1;
        checkVal("rst_s1_b", 32'(S1BEG), 32'h0000_0005);
        checkVal("rst_s4", 32'(S4BEG), 32'h0000_0F0F);
        checkVal("rst_clko_hi", 32'(UserCLKo), 32'(UserCLK));
        Reset = 1'b0; FrameStrobe = '0; FrameData = '0; N4END = '0;
        step();
        step();

        // All RETIME: N4END appears exactly two edges later
        writeCfg(8'h55);
        N4END = 16'h1234;
        #1;
        checkVal("rt_k", 32'(S4BEG), 32'h0000_0000);
        step();
        checkVal("rt_k1", 32'(S4BEG), 32'h0000_0000);
        step();
        checkVal("rt_k2", 32'(S4BEG), 32'h0000_1234);

        // Ramp on N2MID, freeze G2, then resume
        N2MID = 8'h10; step();
        N2MID = 8'h11; step();
        checkVal("ramp", 32'(S2BEG), 32'h0000_0010);
        N2MID = 8'h12;
        writeCfg(8'h59);
        checkVal("frz0", 32'(S2BEG), 32'h0000_0011);
        N2MID = 8'h13; step();
        checkVal("frz1", 32'(S2BEG), 32'h0000_0011);
        checkVal("frz_g4", 32'(S4BEG), 32'h0000_1234);
        N2MID = 8'h14; step();
        checkVal("frz2", 32'(S2BEG), 32'h0000_0011);
        N2MID = 8'h15;
        writeCfg(8'h55);
        checkVal("frz_rel", 32'(S2BEG), 32'h0000_0011);
        N2MID = 8'h16; step();
        checkVal("resume0", 32'(S2BEG), 32'h0000_0012);
        N2MID = 8'h17; step();
        checkVal("resume1", 32'(S2BEG), 32'h0000_0016);

        // G2b ZERO while the pipeline fills, then RETIME shows it at once
        N2END = 8'hFF;
        writeCfg(8'h75);
        checkVal("zero0", 32'(S2BEGb), 32'h0000_0000);
        step();
        checkVal("zero1", 32'(S2BEGb), 32'h0000_0000);
        writeCfg(8'h55);
        checkVal("zero_rt", 32'(S2BEGb), 32'h0000_00FF);

        // Asynchronous reset between edges while retiming
        N4END = 16'hABCD; step(); step();
        checkVal("pre_rst", 32'(S4BEG), 32'h0000_ABCD);
        N4END = 16'h5A5A;
        #1;
        checkVal("pre_rst_hold", 32'(S4BEG), 32'h0000_ABCD);
        #2;
        Reset = 1'b1;
        #1;
        checkVal("async_rst_s4", 32'(S4BEG), 32'h0000_5A5A);
        N2MID = 8'h77;
        #1;
        checkVal("async_rst_s2", 32'(S2BEG), 32'h0000_0077);
        step();
        Reset = 1'b0;
        writeCfg(8'h00);
        N4END = 16'h6B6B;
        #1;
        checkVal("post_rst_byp", 32'(S4BEG), 32'h0000_6B6B);

        // Strobe held two edges: last write (C3) wins
        FrameData   = 32'h0000_FF00;
        FrameStrobe = 20'h00001;
        step();
        FrameData   = 32'h0000_C300;
        step();
        FrameStrobe = '0;
        N1END = 4'h9; N2MID = 8'h3C; N2END = 8'hC3; N4END = 16'hBEEF;
        #1;
        checkVal("c3_g1_zero", 32'(S1BEG), 32'h0000_0000);
        checkVal("c3_g2_byp", 32'(S2BEG), 32'h0000_003C);
        checkVal("c3_g2b_byp", 32'(S2BEGb), 32'h0000_00C3);
        checkVal("c3_g4_zero", 32'(S4BEG), 32'h0000_0000);

        // Strobes on other frames only pass through
        FrameStrobe = 20'hA5A5A;
        FrameData   = 32'h0000_5500;
        #1;
        checkVal("fso_pass", 32'(FrameStrobe_O), 32'h000A_5A5A);
        step();
        N2MID = 8'h4D;
        #1;
        checkVal("no_cfg_write", 32'(S2BEG), 32'h0000_004D);
        FrameStrobe = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
